// File: rtl/gpr_ctl_pkg.sv
// Shared constants for the GPR controller: register-file geometry, controller
// state encoding and the writeback source tag used by the arbiter.
package gpr_ctl_pkg;

  localparam int GPR_N  = 32;
  localparam int GPR_AW = 5;
  localparam int GPR_DW = 32;

  localparam logic [1:0] ST_INIT    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_DBG_RD  = 2'd2;
  localparam logic [1:0] ST_DBG_ACK = 2'd3;

  typedef enum logic {
    SRC_EX = 1'b0,
    SRC_LD = 1'b1
  } wb_src_e;

endpackage

// File: rtl/gpr_wb_arb.sv
// Two-requester writeback arbiter (execute vs load). Grants are combinational
// from the same-cycle valids; RR_ARB selects round-robin or fixed ld priority.
module gpr_wb_arb
  import gpr_ctl_pkg::*;
#(
  parameter int RR_ARB = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ex_valid,
  input  logic ld_valid,
  output logic ex_grant,
  output logic ld_grant
);

  wb_src_e last_src;

  always_comb begin
    ex_grant = 1'b0;
    ld_grant = 1'b0;
    if (en) begin
      if (ex_valid && ld_valid) begin
        if ((RR_ARB != 0) && (last_src == SRC_LD)) ex_grant = 1'b1;
        else                                        ld_grant = 1'b1;
      end else begin
        ex_grant = ex_valid;
        ld_grant = ld_valid;
      end
    end
  end

  // A grant always completes a transfer because ready is the grant itself.
  always_ff @(posedge clk) begin
    if (rst)           last_src <= SRC_EX;
    else if (ex_grant) last_src <= SRC_EX;
    else if (ld_grant) last_src <= SRC_LD;
  end

endmodule

// File: rtl/gpr_ctl.sv
// GPR controller: post-reset zero sweep, ex/ld writeback arbitration onto the
// register-file write port, and debug read/write access through read port 2.
module gpr_ctl
  import gpr_ctl_pkg::*;
#(
  parameter int INIT_ON_RESET = 1,
  parameter int RR_ARB        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_wr_valid,
  output logic              ex_wr_ready,
  input  logic [GPR_AW-1:0] ex_wr_adr,
  input  logic [GPR_DW-1:0] ex_wr_dat,
  input  logic              ld_wr_valid,
  output logic              ld_wr_ready,
  input  logic [GPR_AW-1:0] ld_wr_adr,
  input  logic [GPR_DW-1:0] ld_wr_dat,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [GPR_AW-1:0] dbg_adr,
  input  logic [GPR_DW-1:0] dbg_wdat,
  output logic              dbg_ack,
  output logic [GPR_DW-1:0] dbg_rdat,
  input  logic [GPR_AW-1:0] core_rd_adr_2,
  output logic              core_rd2_stall,
  output logic              gpr_wr_en,
  output logic [GPR_AW-1:0] gpr_wr_adr,
  output logic [GPR_DW-1:0] gpr_wr_dat,
  output logic [GPR_AW-1:0] gpr_rd_adr_2,
  input  logic [GPR_DW-1:0] gpr_rd_dat_2,
  output logic              init_busy
);

  localparam logic [1:0] RST_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

  logic [1:0]        state;
  logic [GPR_AW-1:0] cnt;
  logic [GPR_AW-1:0] dbg_adr_q;
  logic              rd_ack_q;
  logic              arb_en;
  logic              dbg_rd_hold;
  logic              ex_grant;
  logic              ld_grant;
  logic              dbg_wr_acc;
  logic              dbg_rd_acc;

  // Outputs are gated by rst so the reset cycle itself presents idle values.
  assign arb_en      = !rst && (state != ST_INIT);
  assign dbg_rd_hold = !rst && ((state == ST_DBG_RD) || (state == ST_DBG_ACK));

  gpr_wb_arb #(.RR_ARB(RR_ARB)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .en       (arb_en),
    .ex_valid (ex_wr_valid),
    .ld_valid (ld_wr_valid),
    .ex_grant (ex_grant),
    .ld_grant (ld_grant)
  );

  assign ex_wr_ready = ex_grant;
  assign ld_wr_ready = ld_grant;

  // Debug writes take the write port only when neither writeback is asking.
  assign dbg_wr_acc = !rst && (state == ST_RUN) && dbg_req && dbg_we &&
                      !ex_wr_valid && !ld_wr_valid;
  assign dbg_rd_acc = !rst && (state == ST_RUN) && dbg_req && !dbg_we;

  assign dbg_ack        = dbg_wr_acc || (rd_ack_q && !rst);
  assign init_busy      = rst ? (INIT_ON_RESET != 0) : (state == ST_INIT);
  assign core_rd2_stall = dbg_rd_hold;
  assign gpr_rd_adr_2   = dbg_rd_hold ? dbg_adr_q : core_rd_adr_2;

  always_comb begin
    gpr_wr_en  = 1'b0;
    gpr_wr_adr = '0;
    gpr_wr_dat = '0;
    if (!rst && (state == ST_INIT)) begin
      gpr_wr_en  = 1'b1;
      gpr_wr_adr = cnt;
    end else if (ex_grant) begin
      gpr_wr_en  = 1'b1;
      gpr_wr_adr = ex_wr_adr;
      gpr_wr_dat = ex_wr_dat;
    end else if (ld_grant) begin
      gpr_wr_en  = 1'b1;
      gpr_wr_adr = ld_wr_adr;
      gpr_wr_dat = ld_wr_dat;
    end else if (dbg_wr_acc) begin
      gpr_wr_en  = 1'b1;
      gpr_wr_adr = dbg_adr;
      gpr_wr_dat = dbg_wdat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RST_STATE;
      cnt      <= '0;
      rd_ack_q <= 1'b0;
      dbg_rdat <= '0;
    end else begin
      rd_ack_q <= (state == ST_DBG_ACK);
      case (state)
        ST_INIT: begin
          cnt <= cnt + 5'd1;
          if (cnt == GPR_AW'(GPR_N - 1)) state <= ST_RUN;
        end
        ST_RUN:     if (dbg_rd_acc) state <= ST_DBG_RD;
        ST_DBG_RD:  state <= ST_DBG_ACK;
        // Address has been stable for two cycles, so either file style is valid here.
        ST_DBG_ACK: begin
          dbg_rdat <= gpr_rd_dat_2;
          state    <= ST_RUN;
        end
        default:    state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (dbg_rd_acc) dbg_adr_q <= dbg_adr;
  end

endmodule

// File: tb/tb_gpr_ctl.sv
// Scoreboard bench for gpr_ctl: a behavioural model predicts per-cycle outputs,
// writes and debug acks into queues; a negedge monitor pops and compares.
module tb_gpr_ctl;
  import gpr_ctl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ex_wr_valid, ld_wr_valid, dbg_req, dbg_we;
  logic [4:0]  ex_wr_adr, ld_wr_adr, dbg_adr, core_rd_adr_2;
  logic [31:0] ex_wr_dat, ld_wr_dat, dbg_wdat;
  logic        ex_wr_ready, ld_wr_ready, dbg_ack, core_rd2_stall, gpr_wr_en, init_busy;
  logic [31:0] dbg_rdat, gpr_wr_dat, gpr_rd_dat_2;
  logic [4:0]  gpr_wr_adr, gpr_rd_adr_2;

  // Second instance: fixed priority, no init sweep, debug port idle.
  logic        ex_wr_ready2, ld_wr_ready2, dbg_ack2, core_rd2_stall2, gpr_wr_en2, init_busy2;
  logic [31:0] dbg_rdat2, gpr_wr_dat2;
  logic [4:0]  gpr_wr_adr2, gpr_rd_adr2;
  logic        tie0;
  logic [4:0]  tie_adr;
  logic [31:0] tie_dat;
  assign tie0 = 1'b0;
  assign tie_adr = 5'd0;
  assign tie_dat = 32'd0;

  logic [31:0] rf [32];
  always @(posedge clk) if (gpr_wr_en === 1'b1) rf[gpr_wr_adr] <= gpr_wr_dat;
  assign gpr_rd_dat_2 = rf[gpr_rd_adr_2];

  gpr_ctl #(.INIT_ON_RESET(1), .RR_ARB(1)) dut (
    .clk(clk), .rst(rst),
    .ex_wr_valid(ex_wr_valid), .ex_wr_ready(ex_wr_ready), .ex_wr_adr(ex_wr_adr), .ex_wr_dat(ex_wr_dat),
    .ld_wr_valid(ld_wr_valid), .ld_wr_ready(ld_wr_ready), .ld_wr_adr(ld_wr_adr), .ld_wr_dat(ld_wr_dat),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdat(dbg_wdat),
    .dbg_ack(dbg_ack), .dbg_rdat(dbg_rdat),
    .core_rd_adr_2(core_rd_adr_2), .core_rd2_stall(core_rd2_stall),
    .gpr_wr_en(gpr_wr_en), .gpr_wr_adr(gpr_wr_adr), .gpr_wr_dat(gpr_wr_dat),
    .gpr_rd_adr_2(gpr_rd_adr_2), .gpr_rd_dat_2(gpr_rd_dat_2), .init_busy(init_busy)
  );

  gpr_ctl #(.INIT_ON_RESET(0), .RR_ARB(0)) dut2 (
    .clk(clk), .rst(rst),
    .ex_wr_valid(ex_wr_valid), .ex_wr_ready(ex_wr_ready2), .ex_wr_adr(ex_wr_adr), .ex_wr_dat(ex_wr_dat),
    .ld_wr_valid(ld_wr_valid), .ld_wr_ready(ld_wr_ready2), .ld_wr_adr(ld_wr_adr), .ld_wr_dat(ld_wr_dat),
    .dbg_req(tie0), .dbg_we(tie0), .dbg_adr(tie_adr), .dbg_wdat(tie_dat),
    .dbg_ack(dbg_ack2), .dbg_rdat(dbg_rdat2),
    .core_rd_adr_2(tie_adr), .core_rd2_stall(core_rd2_stall2),
    .gpr_wr_en(gpr_wr_en2), .gpr_wr_adr(gpr_wr_adr2), .gpr_wr_dat(gpr_wr_dat2),
    .gpr_rd_adr_2(gpr_rd_adr2), .gpr_rd_dat_2(tie_dat), .init_busy(init_busy2)
  );

  typedef struct { int cyc; logic [4:0] adr; logic [31:0] dat; } wr_t;
  typedef struct { int cyc; logic [31:0] rdat; } ack_t;
  typedef struct {
    int cyc;
    logic ex_rdy, ld_rdy, busy, stall;
    logic [4:0] rd_adr;
    logic ex2, ld2, wen2;
    logic [4:0] wadr2;
  } cyc_t;

  wr_t  wr_q [$];
  ack_t ack_q [$];
  cyc_t cyc_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Reference model state: counts and queues, not the controller's encoding.
  int          init_left;
  bit          pref_ld;
  int          rd_left;
  logic [4:0]  rd_adr_m;
  logic [31:0] cap, last_rdat;
  logic [31:0] shadow [32];
  bit          dbg_accepted;

  task automatic model_step();
    cyc_t e;
    wr_t  w;
    ack_t a;
    bit   gex, gld, wr_m;
    e.cyc    = cyc;
    e.ld2    = !rst && ld_wr_valid;
    e.ex2    = !rst && ex_wr_valid && !ld_wr_valid;
    e.wen2   = e.ld2 || e.ex2;
    e.wadr2  = e.ld2 ? ld_wr_adr : ex_wr_adr;
    e.ex_rdy = 1'b0; e.ld_rdy = 1'b0; e.stall = 1'b0; e.busy = 1'b0;
    e.rd_adr = core_rd_adr_2;
    dbg_accepted = 1'b0;
    wr_m = 1'b0;
    if (rst) begin
      init_left = 32; pref_ld = 1'b1; rd_left = 0; last_rdat = '0; e.busy = 1'b1;
    end else if (init_left > 0) begin
      e.busy = 1'b1;
      w.cyc = cyc; w.adr = 5'(32 - init_left); w.dat = '0; wr_m = 1'b1;
      init_left--;
    end else begin
      if (rd_left == 1) begin
        a.cyc = cyc; a.rdat = cap; last_rdat = cap; ack_q.push_back(a);
      end
      if (rd_left > 1) begin
        e.stall = 1'b1; e.rd_adr = rd_adr_m;
        if (rd_left == 2) cap = shadow[rd_adr_m];
      end
      gld = ld_wr_valid && (!ex_wr_valid || pref_ld);
      gex = ex_wr_valid && !gld;
      e.ex_rdy = gex; e.ld_rdy = gld;
      if (gex || gld) begin
        pref_ld = gex;
        w.cyc = cyc; w.adr = gld ? ld_wr_adr : ex_wr_adr; w.dat = gld ? ld_wr_dat : ex_wr_dat;
        wr_m = 1'b1;
      end else if (rd_left <= 1 && dbg_req && dbg_we) begin
        w.cyc = cyc; w.adr = dbg_adr; w.dat = dbg_wdat; wr_m = 1'b1;
        a.cyc = cyc; a.rdat = last_rdat; ack_q.push_back(a);
        dbg_accepted = 1'b1;
      end
      if (rd_left <= 1 && dbg_req && !dbg_we) begin
        rd_left = 4; rd_adr_m = dbg_adr; dbg_accepted = 1'b1;
      end
      if (rd_left > 0) rd_left--;
    end
    if (wr_m) begin
      wr_q.push_back(w);
      shadow[w.adr] = w.dat;
    end
    cyc_q.push_back(e);
  endtask

  cyc_t me;
  wr_t  mw;
  ack_t ma;
  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc_q.size() == 0) chk("cyc_expectation_present", 0, 1);
      else begin
        me = cyc_q.pop_front();
        chk("cyc_stamp", cyc, me.cyc);
        chk("ex_wr_ready", ex_wr_ready, me.ex_rdy);
        chk("ld_wr_ready", ld_wr_ready, me.ld_rdy);
        chk("init_busy", init_busy, me.busy);
        chk("core_rd2_stall", core_rd2_stall, me.stall);
        chk("gpr_rd_adr_2", gpr_rd_adr_2, me.rd_adr);
        chk("fp_ex_wr_ready", ex_wr_ready2, me.ex2);
        chk("fp_ld_wr_ready", ld_wr_ready2, me.ld2);
        chk("fp_init_busy", init_busy2, 1'b0);
        chk("fp_gpr_wr_en", gpr_wr_en2, me.wen2);
        if (me.wen2) chk("fp_gpr_wr_adr", gpr_wr_adr2, me.wadr2);
      end
      while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
        mw = wr_q.pop_front();
        chk("missing_write_adr", 32'hFFFF_FFFF, mw.adr);
      end
      if (gpr_wr_en === 1'b1) begin
        if (wr_q.size() == 0) chk("unexpected_write_adr", gpr_wr_adr, 32'hFFFF_FFFF);
        else begin
          mw = wr_q.pop_front();
          chk("wr_cyc", cyc, mw.cyc);
          chk("wr_adr", gpr_wr_adr, mw.adr);
          chk("wr_dat", gpr_wr_dat, mw.dat);
        end
      end else chk("gpr_wr_en_low", gpr_wr_en, 1'b0);
      while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
        ma = ack_q.pop_front();
        chk("missing_dbg_ack_cyc", 32'hFFFF_FFFF, ma.cyc);
      end
      if (dbg_ack === 1'b1) begin
        if (ack_q.size() == 0) chk("unexpected_dbg_ack", dbg_ack, 1'b0);
        else begin
          ma = ack_q.pop_front();
          chk("ack_cyc", cyc, ma.cyc);
          chk("dbg_rdat", dbg_rdat, ma.rdat);
        end
      end else chk("dbg_ack_low", dbg_ack, 1'b0);
    end
  end

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_wr_valid = 1'b0; ld_wr_valid = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
    ex_wr_adr = '0; ld_wr_adr = '0; dbg_adr = '0; core_rd_adr_2 = '0;
    ex_wr_dat = '0; ld_wr_dat = '0; dbg_wdat = '0;
  endtask

  task automatic rand_wb(input bit ex_v, input bit ld_v);
    ex_wr_valid = ex_v; ld_wr_valid = ld_v;
    ex_wr_adr = 5'($urandom); ld_wr_adr = 5'($urandom);
    ex_wr_dat = $urandom; ld_wr_dat = $urandom;
    core_rd_adr_2 = 5'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    tick();
    // Reset mid-sweep at cnt=10, then a full sweep.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) tick();
    // Both writebacks valid continuously.
    for (int i = 0; i < 8; i++) begin rand_wb(1'b1, 1'b1); tick(); end
    // Debug write r5 held off by ex traffic.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_adr = 5'd5; dbg_wdat = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin rand_wb(1'b1, 1'b0); tick(); end
    rand_wb(1'b0, 1'b0);
    tick();
    dbg_req = 1'b0;
    tick();
    // Seed r7 then read it back.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_adr = 5'd7; dbg_wdat = 32'h12345678;
    tick();
    dbg_we = 1'b0; dbg_wdat = '0;
    tick();
    dbg_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    // Reset while in the first debug-read cycle: no ack may follow.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 5'd5;
    tick();
    dbg_req = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 34; i++) tick();
    // Randomized traffic with interleaved debug accesses.
    for (int i = 0; i < 400; i++) begin
      rand_wb($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      if (!dbg_req && rd_left == 0 && $urandom_range(0, 4) == 0) begin
        dbg_req = 1'b1; dbg_we = $urandom_range(0, 1) == 1;
        dbg_adr = 5'($urandom); dbg_wdat = $urandom;
      end
      tick();
      if (dbg_accepted) dbg_req = 1'b0;
    end
    idle_inputs();
    for (int i = 0; i < 5; i++) tick();
    mon_en = 1'b0;
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("ack_queue_drained", ack_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpr_ctl.md
GPR_CTL -- requirements
Module: gpr_ctl

Interface
REQ-001 SHALL have parameter INIT_ON_RESET, default 1: 1 = zero all 32 GPRs after reset; 0 = skip init.
REQ-002 SHALL have parameter RR_ARB, default 1: 1 = round-robin ex/ld arbitration; 0 = fixed priority, ld over ex.
REQ-003 clk  in  1  the one clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 ex_wr_valid/ex_wr_ready  in/out  1/1  execute writeback handshake.
REQ-006 ex_wr_adr/ex_wr_dat  in  5/32  execute writeback target and data.
REQ-007 ld_wr_valid/ld_wr_ready  in/out  1/1  load writeback handshake.
REQ-008 ld_wr_adr/ld_wr_dat  in  5/32  load writeback target and data.
REQ-009 dbg_req/dbg_we  in  1/1  debug access request; 1 = write, 0 = read.
REQ-010 dbg_adr/dbg_wdat  in  5/32  debug address and write data.
REQ-011 dbg_ack/dbg_rdat  out  1/32  debug completion pulse and read data.
REQ-012 core_rd_adr_2  in  5  core address for GPR read port 2.
REQ-013 core_rd2_stall  out  1  port 2 is taken by debug; core data on port 2 is invalid.
REQ-014 gpr_wr_en/gpr_wr_adr/gpr_wr_dat  out  1/5/32  register-file write port.
REQ-015 gpr_rd_adr_2/gpr_rd_dat_2  out/in  5/32  register-file read port 2.
REQ-016 init_busy  out  1  init sweep in progress.

Function
REQ-017 States SHALL be INIT, RUN, DBG_RD and DBG_ACK.
REQ-018 INIT, each cycle: gpr_wr_en=1, gpr_wr_adr=cnt, gpr_wr_dat=0, cnt+1; cnt==31 -> RUN; exactly 32 writes (r0..r31).
REQ-019 INIT: ex_wr_ready=ld_wr_ready=0; dbg_ack=0; init_busy=1.
REQ-020 RUN: ex/ld grant SHALL be combinational from the same-cycle valids; ready=grant; transfer = valid&ready.
REQ-021 Both valid, RR_ARB=1: grant the requester not granted last; pointer updates only on a transfer; pointer reset value favours ld.
REQ-022 Both valid, RR_ARB=0: grant ld.
REQ-023 A granted writeback SHALL drive gpr_wr_en=1 with its own adr/dat in the same cycle (zero added latency).
REQ-024 Debug write is lowest priority: accept only in RUN with dbg_req&dbg_we and neither ex nor ld valid.
REQ-025 Accepted debug write: write in that cycle, dbg_ack=1 in that cycle, stay in RUN.
REQ-026 Debug read accepted in RUN when dbg_req&!dbg_we (no write-port needed) -> DBG_RD.
REQ-027 DBG_RD and DBG_ACK: gpr_rd_adr_2=dbg_adr latched at acceptance; core_rd2_stall=1.
REQ-028 DBG_RD -> DBG_ACK unconditionally.
REQ-029 DBG_ACK: dbg_rdat <= gpr_rd_dat_2 (registered); dbg_ack=1 the following cycle; -> RUN.
REQ-030 The two-cycle address hold SHALL make debug reads correct for both combinational and registered-read register files.
REQ-031 ex/ld arbitration SHALL continue unaffected during DBG_RD and DBG_ACK.
REQ-032 Outside DBG_RD and DBG_ACK: gpr_rd_adr_2=core_rd_adr_2; core_rd2_stall=0.
REQ-033 dbg_ack SHALL be a single-cycle pulse; dbg_req must drop or change before the next access, otherwise it is a new request.
REQ-034 gpr_wr_en=0 when no write is granted; gpr_wr_adr and gpr_wr_dat are don't-care then.
REQ-035 Same-address debug read and writeback in one cycle: read returns the file's read-during-write behaviour; no bypass.

Reset
REQ-036 rst at any cycle, including mid-INIT or mid-debug read, SHALL abort the operation and load: state=INIT (RUN if INIT_ON_RESET=0), cnt=0, rr pointer=ld.
REQ-037 Reset output values: gpr_wr_en=0, dbg_ack=0, dbg_rdat=0, core_rd2_stall=0, readies=0, init_busy=INIT_ON_RESET.
REQ-038 A debug read aborted by reset SHALL NOT be acknowledged.

Structure
REQ-039 The state encoding and the GPR count/width constants (32, 5, 32) SHALL be defined in the shared defs include.
REQ-040 The two-requester round-robin arbiter SHALL be sub-module gpr_wb_arb; everything else is flat.
REQ-041 The block SHALL sit beside the gpr instance and drive its write port and read port 2; it is not instantiated inside gpr.

Verification
REQ-042 Init: release rst -> 32 consecutive writes of 0, addresses 0..31; init_busy falls on cycle 32; readies high from cycle 32.
REQ-043 Round-robin: ex and ld valid continuously, RR_ARB=1 -> grants ld, ex, ld, ex...; every write reaches gpr_wr_* in its grant cycle.
REQ-044 Fixed priority: ex and ld valid continuously, RR_ARB=0 -> ld always granted, ex starved.
REQ-045 Debug write: dbg write r5=0xDEADBEEF with ex valid -> no ack while ex is valid; written and acked the first cycle ex is idle.
REQ-046 Debug read: r7 holds 0x12345678, dbg read r7 -> core_rd2_stall high for 2 cycles, dbg_ack with dbg_rdat=0x12345678 on cycle 3.
REQ-047 Reset mid-operation: assert rst at init cnt=10 -> sweep restarts at r0; assert rst in DBG_RD -> no dbg_ack.
